mario_status_tracker: RTL and testbench

- Upstream producer of the `mario_alive` and `GAMEEND` status flags. The screen phase controller consumes both.
- Tracks the lives counter, the power-up (big) state, post-hit invulnerability frames, the death-animation delay and the flag-pole sequence.
- Driven by per-cycle collision pulses from the collision unit and a once-per-frame tick from the VGA controller.
- Outputs also feed the sprite renderer (`invuln` flicker, `dying`, `flag_anim`) and the HUD (`lives`).

---
 rtl/mario_status_if.sv | 36 +++
 rtl/mario_status_tracker.sv | 135 +++++++++++++
 tb/tb_mario_status_tracker.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mario_status_if.sv
// Collision/status bundle between the collision unit, the status tracker and
// its consumers (phase controller, sprite renderer, HUD).
interface mario_status_if #(
    parameter int LIVES_W = 3
);
    logic               frame_tick;
    logic               game_active;
    logic               enemy_hit;
    logic               stomp;
    logic               hazard_hit;
    logic               mushroom;
    logic               flag_touch;
    logic               one_up;
    logic               mario_alive;
    logic               GAMEEND;
    logic [LIVES_W-1:0] lives;
    logic               big;
    logic               invuln;
    logic               dying;
    logic               flag_anim;
    logic               respawn;

    modport master (
        output frame_tick, game_active, enemy_hit, stomp, hazard_hit,
               mushroom, flag_touch, one_up,
        input  mario_alive, GAMEEND, lives, big, invuln, dying, flag_anim,
               respawn
    );

    modport slave (
        input  frame_tick, game_active, enemy_hit, stomp, hazard_hit,
               mushroom, flag_touch, one_up,
        output mario_alive, GAMEEND, lives, big, invuln, dying, flag_anim,
               respawn
    );
endinterface

// File: rtl/mario_status_tracker.sv
// Lives / power-up / invulnerability / death / flag-pole tracker.
// Optional extra-life pickups are enabled with `define MARIO_EXTRA_LIFE_EN.
module mario_status_tracker #(
    parameter int START_LIVES   = 3,
    parameter int LIVES_W       = 3,
    parameter int INVULN_FRAMES = 120,
    parameter int DEATH_FRAMES  = 90,
    parameter int FLAG_FRAMES   = 60,
    parameter int TMR_W         = 8
) (
    input  logic           CLK,
    input  logic           RESET,
    mario_status_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, PLAY, INVULN, DYING, FLAG, OVER, WON
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [LIVES_W-1:0] lives_q;
    logic               alive_q;
    logic               gameend_q;
    logic               big_q;
    logic               respawn_q;
    logic               eff_hit;
    logic               tmr_last;

    assign eff_hit  = bus.enemy_hit & ~bus.stomp;
    assign tmr_last = (timer <= TMR_W'(1));

`ifdef MARIO_EXTRA_LIFE_EN
    function automatic logic [LIVES_W-1:0] lives_inc(input logic [LIVES_W-1:0] v);
        return (v == {LIVES_W{1'b1}}) ? v : v + 1'b1;
    endfunction
`else
    logic unused_one_up;
    assign unused_one_up = bus.one_up;
`endif

    always_ff @(posedge CLK) begin
        respawn_q <= 1'b0;
        if (RESET) begin
            state     <= IDLE;
            timer     <= '0;
            lives_q   <= LIVES_W'(START_LIVES);
            alive_q   <= 1'b1;
            gameend_q <= 1'b0;
            big_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.game_active) state <= PLAY;

                PLAY: if (bus.game_active) begin
`ifdef MARIO_EXTRA_LIFE_EN
                    if (bus.one_up) lives_q <= lives_inc(lives_q);
`endif
                    if (bus.flag_touch) begin
                        state <= FLAG;
                        timer <= TMR_W'(FLAG_FRAMES);
                    end else if (bus.hazard_hit) begin
                        state <= DYING;
                        timer <= TMR_W'(DEATH_FRAMES);
                        big_q <= 1'b0;
                    end else if (eff_hit && big_q) begin
                        state <= INVULN;
                        timer <= TMR_W'(INVULN_FRAMES);
                        big_q <= 1'b0;
                    end else if (eff_hit) begin
                        state <= DYING;
                        timer <= TMR_W'(DEATH_FRAMES);
                    end else if (bus.mushroom) begin
                        big_q <= 1'b1;
                    end
                end

                // Enemy contact is harmless here; only hazards and the flag preempt the countdown.
                INVULN: if (bus.game_active) begin
`ifdef MARIO_EXTRA_LIFE_EN
                    if (bus.one_up) lives_q <= lives_inc(lives_q);
`endif
                    if (bus.flag_touch) begin
                        state <= FLAG;
                        timer <= TMR_W'(FLAG_FRAMES);
                    end else if (bus.hazard_hit) begin
                        state <= DYING;
                        timer <= TMR_W'(DEATH_FRAMES);
                        big_q <= 1'b0;
                    end else begin
                        if (bus.mushroom) big_q <= 1'b1;
                        if (bus.frame_tick) begin
                            if (tmr_last) state <= PLAY;
                            else          timer <= timer - 1'b1;
                        end
                    end
                end

                DYING: if (bus.game_active && bus.frame_tick) begin
                    if (!tmr_last) begin
                        timer <= timer - 1'b1;
                    end else if (lives_q > LIVES_W'(1)) begin
                        lives_q   <= lives_q - 1'b1;
                        respawn_q <= 1'b1;
                        big_q     <= 1'b0;
                        state     <= PLAY;
                    end else begin
                        lives_q <= '0;
                        alive_q <= 1'b0;
                        state   <= OVER;
                    end
                end

                FLAG: if (bus.game_active && bus.frame_tick) begin
                    if (!tmr_last) begin
                        timer <= timer - 1'b1;
                    end else begin
                        gameend_q <= 1'b1;
                        state     <= WON;
                    end
                end

                default: state <= state;
            endcase
        end
    end

    assign bus.mario_alive = alive_q;
    assign bus.GAMEEND     = gameend_q;
    assign bus.lives       = lives_q;
    assign bus.big         = big_q;
    assign bus.respawn     = respawn_q;
    assign bus.invuln      = (state == INVULN);
    assign bus.dying       = (state == DYING);
    assign bus.flag_anim   = (state == FLAG);
endmodule

// File: tb/tb_mario_status_tracker.sv
// Scoreboard bench for mario_status_tracker: a rule-level model predicts the
// outputs after every edge, and a monitor compares them one edge later.
module tb_mario_status_tracker;
    localparam int LW  = 3;
    localparam int SL  = 3;
    localparam int INV = 120;
    localparam int DTH = 90;
    localparam int FLG = 60;
    localparam int OW  = LW + 7;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    mario_status_if #(.LIVES_W(LW)) bus();

    mario_status_tracker #(
        .START_LIVES(SL), .LIVES_W(LW), .INVULN_FRAMES(INV),
        .DEATH_FRAMES(DTH), .FLAG_FRAMES(FLG), .TMR_W(8)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    typedef enum {M_IDLE, M_PLAY, M_SAFE, M_DEAD, M_POLE, M_LOST, M_DONE} mphase_t;

    mphase_t m_ph;
    int      m_left;
    int      m_lives;
    bit      m_alive, m_won, m_big, m_resp;

    logic [OW-1:0] exp_q[$];
    int  tests = 0;
    int  fails = 0;
    bit  cur_ga = 1'b0;

    function automatic logic [OW-1:0] exp_vec();
        logic [LW-1:0] l;
        l = LW'(m_lives);
        return {m_alive, m_won, l, m_big, (m_ph == M_SAFE), (m_ph == M_DEAD),
                (m_ph == M_POLE), m_resp};
    endfunction

    // One clock of the game rules, expressed as "frames left" bookkeeping.
    task automatic model(input bit r, ga, tk, eh, st, hz, mu, fl, ou);
        bit hit;
        hit    = eh && !st;
        m_resp = 1'b0;
        if (r) begin
            m_ph = M_IDLE; m_left = 0; m_lives = SL;
            m_alive = 1'b1; m_won = 1'b0; m_big = 1'b0;
            return;
        end
        if (m_ph == M_IDLE) begin
            if (ga) m_ph = M_PLAY;
            return;
        end
        if (!ga || m_ph == M_LOST || m_ph == M_DONE) return;
`ifdef MARIO_EXTRA_LIFE_EN
        if ((m_ph == M_PLAY || m_ph == M_SAFE) && ou && m_lives < (1 << LW) - 1)
            m_lives++;
`endif
        case (m_ph)
            M_PLAY: begin
                if (fl)            begin m_ph = M_POLE; m_left = FLG; end
                else if (hz)       begin m_ph = M_DEAD; m_left = DTH; m_big = 1'b0; end
                else if (hit)      begin
                    if (m_big) begin m_ph = M_SAFE; m_left = INV; m_big = 1'b0; end
                    else       begin m_ph = M_DEAD; m_left = DTH; end
                end
                else if (mu)       m_big = 1'b1;
            end
            M_SAFE: begin
                if (fl)            begin m_ph = M_POLE; m_left = FLG; end
                else if (hz)       begin m_ph = M_DEAD; m_left = DTH; m_big = 1'b0; end
                else begin
                    if (mu) m_big = 1'b1;
                    if (tk) begin
                        m_left--;
                        if (m_left == 0) m_ph = M_PLAY;
                    end
                end
            end
            M_DEAD: if (tk) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_lives > 1) begin
                        m_lives--; m_resp = 1'b1; m_big = 1'b0; m_ph = M_PLAY;
                    end else begin
                        m_lives = 0; m_alive = 1'b0; m_ph = M_LOST;
                    end
                end
            end
            M_POLE: if (tk) begin
                m_left--;
                if (m_left == 0) begin m_won = 1'b1; m_ph = M_DONE; end
            end
            default: ;
        endcase
    endtask

    task automatic cyc(input bit r, ga, tk, eh, st, hz, mu, fl, ou);
        RESET           = r;
        bus.game_active = ga;
        bus.frame_tick  = tk;
        bus.enemy_hit   = eh;
        bus.stomp       = st;
        bus.hazard_hit  = hz;
        bus.mushroom    = mu;
        bus.flag_touch  = fl;
        bus.one_up      = ou;
        model(r, ga, tk, eh, st, hz, mu, fl, ou);
        exp_q.push_back(exp_vec());
        @(negedge CLK);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cyc(0, cur_ga, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            quiet(3);
            cyc(0, cur_ga, 1, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        cur_ga = 1'b0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        quiet(1);
        cur_ga = 1'b1;
        quiet(2);
    endtask

    initial begin : monitor
        logic [OW-1:0] exp_v, act_v;
        forever begin
            @(posedge CLK);
            #1;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty at %0t: DUT output with no prediction", $time);
            end else begin
                exp_v = exp_q.pop_front();
                act_v = {bus.mario_alive, bus.GAMEEND, bus.lives, bus.big,
                         bus.invuln, bus.dying, bus.flag_anim, bus.respawn};
                if (act_v !== exp_v)
                begin
                    fails++;
                    $display("FAIL status at %0t {alive,gameend,lives,big,invuln,dying,flag,respawn} got=%b want=%b",
                             $time, act_v, exp_v);
                end
            end
        end
    end

    initial begin : driver
        bit ga, r, tk, eh, st, hz, mu, fl, ou;
        do_reset();

        // Small hit, death animation, respawn with one life fewer.
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0);
        ticks(DTH + 2);
        // Extra-life pickup at lives = 2.
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
        // Powered hit: invulnerable, second hit ignored at frame 50.
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0);
        ticks(50);
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0);
        ticks(INV - 50 + 2);
        // Stomp cancels the hit.
        cyc(0, 1, 0, 1, 1, 0, 0, 0, 0);
        quiet(2);
        // Hazard during invulnerability kills at once.
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0);
        ticks(5);
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 0);
        ticks(DTH + 2);
        // Hazard until the last life is gone, then terminal hold.
        while (m_ph != M_LOST) begin
            cyc(0, 1, 0, 0, 0, 1, 0, 0, 0);
            ticks(DTH + 1);
        end
        cyc(0, 1, 1, 1, 0, 1, 1, 1, 1);
        ticks(4);
        do_reset();

        // Saturation of extra lives.
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
        // Flag with simultaneous enemy contact, pause at tick 30.
        cyc(0, 1, 0, 1, 0, 0, 0, 1, 0);
        ticks(30);
        cur_ga = 1'b0;
        ticks(10);
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
        cur_ga = 1'b1;
        ticks(FLG - 30 + 2);
        cyc(0, 1, 1, 1, 0, 1, 1, 1, 1);
        quiet(3);

        // Randomized episodes, including occasional mid-sequence resets.
        for (int e = 0; e < 8; e++) begin
            do_reset();
            ga = 1'b1;
            for (int c = 0; c < 2500; c++) begin
                if (ga) ga = ($urandom_range(0, 99) != 0);
                else    ga = ($urandom_range(0, 14) == 0);
                r  = ($urandom_range(0, 2999) == 0);
                tk = ($urandom_range(0, 2) == 0);
                eh = ($urandom_range(0, 59) == 0);
                st = ($urandom_range(0, 2) == 0);
                hz = ($urandom_range(0, 399) == 0);
                mu = ($urandom_range(0, 39) == 0);
                fl = ($urandom_range(0, 799) == 0);
                ou = ($urandom_range(0, 49) == 0);
                cyc(r, ga, tk, eh, st, hz, mu, fl, ou);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
